// File: rtl/multi_clk_divider.sv
// Multi-channel programmable clock divider with double-buffered divisor/high-time.
// New settings take effect at a period boundary, on SYNC, or while a channel is disabled.
module multi_clk_divider #(
    parameter int NCH      = 4,
    parameter int CW       = 20,
    parameter int DIV_RST  = 4,
    parameter int HIGH_RST = 2,
    localparam int LW      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [NCH-1:0] EN,
    input  logic          SYNC,
    input  logic          LOAD,
    input  logic [LW-1:0]  LOAD_CH,
    input  logic [CW-1:0]  DIV_IN,
    input  logic [CW-1:0]  HIGH_IN,
    output logic [NCH-1:0] CLK_DIV,
    output logic [NCH-1:0] TICK,
    output logic [NCH-1:0] PENDING,
    output logic          ERR
);

    logic [CW-1:0]  cnt      [NCH];
    logic [CW-1:0]  act_div  [NCH];
    logic [CW-1:0]  act_high [NCH];
    logic [CW-1:0]  sh_div   [NCH];
    logic [CW-1:0]  sh_high  [NCH];
    logic [CW-1:0]  nxt_div  [NCH];
    logic [CW-1:0]  nxt_high [NCH];
    logic [NCH-1:0] pend_q, clk_q, tick_q;
    logic [NCH-1:0] ld_hit, wrap, apply, nxt_pend;
    logic           err_q, ch_ok, accept;
    logic [CW-1:0]  high_clamp;

    // The shadow seen by the apply path already includes a coincident accepted LOAD,
    // so a write landing on a boundary takes effect without ever showing PENDING.
    always_comb begin
        ch_ok      = (32'(LOAD_CH) < NCH);
        accept     = LOAD && (DIV_IN >= CW'(2)) && ch_ok;
        high_clamp = (HIGH_IN >= DIV_IN) ? (DIV_IN - CW'(1)) : HIGH_IN;
        for (int i = 0; i < NCH; i++) begin
            ld_hit[i]   = accept && (LOAD_CH == LW'(i));
            wrap[i]     = (cnt[i] == (act_div[i] - CW'(1)));
            apply[i]    = SYNC || !EN[i] || wrap[i];
            nxt_div[i]  = ld_hit[i] ? DIV_IN : sh_div[i];
            nxt_high[i] = ld_hit[i] ? high_clamp : sh_high[i];
            nxt_pend[i] = ld_hit[i] || pend_q[i];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NCH; i++) begin
                cnt[i]      <= '0;
                act_div[i]  <= CW'(DIV_RST);
                act_high[i] <= CW'(HIGH_RST);
                sh_div[i]   <= CW'(DIV_RST);
                sh_high[i]  <= CW'(HIGH_RST);
            end
            pend_q <= '0;
            clk_q  <= '0;
            tick_q <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= LOAD && !accept;
            for (int i = 0; i < NCH; i++) begin
                sh_div[i]  <= nxt_div[i];
                sh_high[i] <= nxt_high[i];
                if (SYNC || !EN[i]) begin
                    clk_q[i]  <= 1'b0;
                    tick_q[i] <= 1'b0;
                end else begin
                    clk_q[i]  <= (cnt[i] >= (act_div[i] - act_high[i]));
                    tick_q[i] <= (cnt[i] == '0);
                end
                if (apply[i]) begin
                    cnt[i]    <= '0;
                    pend_q[i] <= 1'b0;
                    if (nxt_pend[i]) begin
                        act_div[i]  <= nxt_div[i];
                        act_high[i] <= nxt_high[i];
                    end
                end else begin
                    cnt[i]    <= cnt[i] + CW'(1);
                    pend_q[i] <= nxt_pend[i];
                end
            end
        end
    end

    assign CLK_DIV = clk_q;
    assign TICK    = tick_q;
    assign PENDING = pend_q;
    assign ERR     = err_q;

endmodule

// File: tb/tb_multi_clk_divider.sv
// Self-checking bench for multi_clk_divider: behavioural model feeds a scoreboard queue,
// plus fixed-pattern checks on the waveforms each scenario is expected to produce.
module tb_multi_clk_divider;

    localparam int NCH      = 3;
    localparam int CW       = 20;
    localparam int DIV_RST  = 4;
    localparam int HIGH_RST = 2;
    localparam int LW       = 2;
    localparam int OW       = 3 * NCH + 1;

    typedef logic [OW-1:0] ovec_t;

    logic           CLK = 1'b0;
    logic           RST;
    logic [NCH-1:0] EN;
    logic           SYNC, LOAD;
    logic [LW-1:0]  LOAD_CH;
    logic [CW-1:0]  DIV_IN, HIGH_IN;
    logic [NCH-1:0] CLK_DIV, TICK, PENDING;
    logic           ERR;

    int    n_checks = 0;
    int    n_fail   = 0;
    ovec_t sb_q[$];
    ovec_t exp_v, got_v;

    logic [CW-1:0]  m_cnt [NCH];
    logic [CW-1:0]  m_div [NCH];
    logic [CW-1:0]  m_high[NCH];
    logic [CW-1:0]  s_div [NCH];
    logic [CW-1:0]  s_high[NCH];
    logic [NCH-1:0] m_pend, m_clk, m_tick;
    logic           m_err;

    multi_clk_divider #(.NCH(NCH), .CW(CW), .DIV_RST(DIV_RST), .HIGH_RST(HIGH_RST)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .SYNC(SYNC), .LOAD(LOAD), .LOAD_CH(LOAD_CH),
        .DIV_IN(DIV_IN), .HIGH_IN(HIGH_IN), .CLK_DIV(CLK_DIV), .TICK(TICK),
        .PENDING(PENDING), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_cnt[c]  = '0;
            m_div[c]  = CW'(DIV_RST);
            m_high[c] = CW'(HIGH_RST);
            s_div[c]  = CW'(DIV_RST);
            s_high[c] = CW'(HIGH_RST);
        end
        m_pend = '0; m_clk = '0; m_tick = '0; m_err = 1'b0;
    endtask

    // Predicts the registered outputs for the coming edge from the inputs now applied.
    task automatic model_edge();
        logic          acc, bnd;
        logic [CW-1:0] hi;
        acc   = LOAD && (DIV_IN >= CW'(2)) && (int'(LOAD_CH) < NCH);
        hi    = (HIGH_IN >= DIV_IN) ? (DIV_IN - CW'(1)) : HIGH_IN;
        m_err = LOAD && !acc;
        for (int c = 0; c < NCH; c++) begin
            if (acc && int'(LOAD_CH) == c) begin
                s_div[c] = DIV_IN; s_high[c] = hi; m_pend[c] = 1'b1;
            end
            bnd = SYNC || !EN[c] || (m_cnt[c] == m_div[c] - CW'(1));
            if (SYNC || !EN[c]) begin
                m_clk[c] = 1'b0; m_tick[c] = 1'b0;
            end else begin
                m_clk[c]  = (m_cnt[c] >= m_div[c] - m_high[c]);
                m_tick[c] = (m_cnt[c] == '0);
            end
            if (bnd) begin
                m_cnt[c] = '0;
                if (m_pend[c]) begin
                    m_div[c] = s_div[c]; m_high[c] = s_high[c]; m_pend[c] = 1'b0;
                end
            end else begin
                m_cnt[c] = m_cnt[c] + CW'(1);
            end
        end
        sb_q.push_back({m_clk, m_tick, m_pend, m_err});
    endtask

    task automatic cycle();
        model_edge();
        @(posedge CLK);
        #1;
        SYNC = 1'b0;
        LOAD = 1'b0;
    endtask

    task automatic set_load(input int ch, input int div, input int high);
        LOAD    = 1'b1;
        LOAD_CH = LW'(ch);
        DIV_IN  = CW'(div);
        HIGH_IN = CW'(high);
    endtask

    task automatic test_reset();
        RST = 1'b1; EN = '0; SYNC = 1'b0; LOAD = 1'b0; LOAD_CH = '0; DIV_IN = '0; HIGH_IN = '0;
        repeat (2) @(posedge CLK);
        #1;
        n_checks++;
        if ({CLK_DIV, TICK, PENDING, ERR} !== '0) begin
            n_fail++;
            $display("FAIL reset_state got=%h exp=0", {CLK_DIV, TICK, PENDING, ERR});
        end
        RST = 1'b0;
        model_reset();
    endtask

    task automatic test_basic();
        EN = 3'b001;
        for (int k = 0; k < 8; k++) begin
            cycle();
            got_v = {CLK_DIV, TICK, PENDING, ERR}; exp_v = sb_q.pop_front(); n_checks++;
            if (got_v !== exp_v) begin
                n_fail++; $display("FAIL basic_sb k=%0d got=%h exp=%h", k, got_v, exp_v);
            end
            n_checks++;
            if (CLK_DIV[0] !== ((k % 4) >= 2) || TICK[0] !== ((k % 4) == 0) || CLK_DIV[2:1] !== 2'b00 || TICK[2:1] !== 2'b00) begin
                n_fail++; $display("FAIL basic_wave k=%0d clk=%b tick=%b", k, CLK_DIV, TICK);
            end
        end
    endtask

    task automatic test_reload();
        EN = 3'b011;
        repeat (2) begin
            cycle();
            got_v = {CLK_DIV, TICK, PENDING, ERR}; exp_v = sb_q.pop_front(); n_checks++;
            if (got_v !== exp_v) begin
                n_fail++; $display("FAIL reload_pre_sb got=%h exp=%h", got_v, exp_v);
            end
        end
        set_load(1, 5, 1);
        cycle();
        got_v = {CLK_DIV, TICK, PENDING, ERR}; exp_v = sb_q.pop_front(); n_checks++;
        if (got_v !== exp_v || PENDING[1] !== 1'b1 || ERR !== 1'b0) begin
            n_fail++; $display("FAIL reload_pending got=%h exp=%h (PENDING[1] must be 1)", got_v, exp_v);
        end
        cycle();
        got_v = {CLK_DIV, TICK, PENDING, ERR}; exp_v = sb_q.pop_front(); n_checks++;
        if (got_v !== exp_v || PENDING[1] !== 1'b0 || CLK_DIV[1] !== 1'b1) begin
            n_fail++; $display("FAIL reload_wrap got=%h exp=%h (old period ends high, PENDING clears)", got_v, exp_v);
        end
        for (int k = 0; k < 10; k++) begin
            cycle();
            got_v = {CLK_DIV, TICK, PENDING, ERR}; exp_v = sb_q.pop_front(); n_checks++;
            if (got_v !== exp_v) begin
                n_fail++; $display("FAIL reload_sb k=%0d got=%h exp=%h", k, got_v, exp_v);
            end
            n_checks++;
            if (CLK_DIV[1] !== ((k % 5) == 4) || TICK[1] !== ((k % 5) == 0)) begin
                n_fail++; $display("FAIL reload_wave k=%0d clk1=%b tick1=%b", k, CLK_DIV[1], TICK[1]);
            end
        end
    endtask

    task automatic test_err();
        set_load(2, 1, 0);
        cycle();
        got_v = {CLK_DIV, TICK, PENDING, ERR}; exp_v = sb_q.pop_front(); n_checks++;
        if (got_v !== exp_v || ERR !== 1'b1 || PENDING !== 3'b000) begin
            n_fail++; $display("FAIL err_div1 got=%h exp=%h (ERR=1, no PENDING)", got_v, exp_v);
        end
        cycle();
        got_v = {CLK_DIV, TICK, PENDING, ERR}; exp_v = sb_q.pop_front(); n_checks++;
        if (got_v !== exp_v || ERR !== 1'b0) begin
            n_fail++; $display("FAIL err_clear got=%h exp=%h", got_v, exp_v);
        end
        set_load(3, 5, 2);
        cycle();
        got_v = {CLK_DIV, TICK, PENDING, ERR}; exp_v = sb_q.pop_front(); n_checks++;
        if (got_v !== exp_v || ERR !== 1'b1 || PENDING !== 3'b000) begin
            n_fail++; $display("FAIL err_badch got=%h exp=%h (ERR=1, no PENDING)", got_v, exp_v);
        end
        repeat (5) begin
            cycle();
            got_v = {CLK_DIV, TICK, PENDING, ERR}; exp_v = sb_q.pop_front(); n_checks++;
            if (got_v !== exp_v) begin
                n_fail++; $display("FAIL err_after_sb got=%h exp=%h", got_v, exp_v);
            end
        end
    endtask

    task automatic test_clamp();
        EN = 3'b011;
        set_load(2, 6, 9);
        cycle();
        got_v = {CLK_DIV, TICK, PENDING, ERR}; exp_v = sb_q.pop_front(); n_checks++;
        if (got_v !== exp_v || PENDING[2] !== 1'b0 || ERR !== 1'b0) begin
            n_fail++; $display("FAIL clamp_load got=%h exp=%h (disabled load applies at once)", got_v, exp_v);
        end
        EN = 3'b111;
        for (int k = 0; k < 12; k++) begin
            cycle();
            got_v = {CLK_DIV, TICK, PENDING, ERR}; exp_v = sb_q.pop_front(); n_checks++;
            if (got_v !== exp_v) begin
                n_fail++; $display("FAIL clamp_sb k=%0d got=%h exp=%h", k, got_v, exp_v);
            end
            n_checks++;
            if (CLK_DIV[2] !== ((k % 6) >= 1) || TICK[2] !== ((k % 6) == 0)) begin
                n_fail++; $display("FAIL clamp_wave k=%0d clk2=%b tick2=%b", k, CLK_DIV[2], TICK[2]);
            end
        end
        EN = 3'b011;
        set_load(2, 6, 0);
        cycle();
        got_v = {CLK_DIV, TICK, PENDING, ERR}; exp_v = sb_q.pop_front(); n_checks++;
        if (got_v !== exp_v) begin
            n_fail++; $display("FAIL high0_load got=%h exp=%h", got_v, exp_v);
        end
        EN = 3'b111;
        for (int k = 0; k < 12; k++) begin
            cycle();
            got_v = {CLK_DIV, TICK, PENDING, ERR}; exp_v = sb_q.pop_front(); n_checks++;
            if (got_v !== exp_v) begin
                n_fail++; $display("FAIL high0_sb k=%0d got=%h exp=%h", k, got_v, exp_v);
            end
            n_checks++;
            if (CLK_DIV[2] !== 1'b0 || TICK[2] !== ((k % 6) == 0)) begin
                n_fail++; $display("FAIL high0_wave k=%0d clk2=%b tick2=%b", k, CLK_DIV[2], TICK[2]);
            end
        end
    endtask

    task automatic test_sync();
        EN = 3'b000;
        cycle();
        void'(sb_q.pop_front());
        set_load(0, 3, 1); cycle(); void'(sb_q.pop_front());
        set_load(1, 4, 2); cycle(); void'(sb_q.pop_front());
        set_load(2, 7, 3); cycle();
        got_v = {CLK_DIV, TICK, PENDING, ERR}; exp_v = sb_q.pop_front(); n_checks++;
        if (got_v !== exp_v || got_v !== '0) begin
            n_fail++; $display("FAIL sync_setup got=%h exp=%h", got_v, exp_v);
        end
        EN = 3'b001;
        repeat (2) begin cycle(); void'(sb_q.pop_front()); end
        EN = 3'b111;
        for (int k = 0; k < 5; k++) begin
            cycle();
            got_v = {CLK_DIV, TICK, PENDING, ERR}; exp_v = sb_q.pop_front(); n_checks++;
            if (got_v !== exp_v) begin
                n_fail++; $display("FAIL sync_pre_sb k=%0d got=%h exp=%h", k, got_v, exp_v);
            end
        end
        SYNC = 1'b1;
        set_load(2, 5, 2);
        cycle();
        got_v = {CLK_DIV, TICK, PENDING, ERR}; exp_v = sb_q.pop_front(); n_checks++;
        if (got_v !== exp_v || got_v !== '0) begin
            n_fail++; $display("FAIL sync_edge got=%h exp=%h (all outputs low, no PENDING)", got_v, exp_v);
        end
        for (int k = 0; k < 10; k++) begin
            cycle();
            got_v = {CLK_DIV, TICK, PENDING, ERR}; exp_v = sb_q.pop_front(); n_checks++;
            if (got_v !== exp_v) begin
                n_fail++; $display("FAIL sync_sb k=%0d got=%h exp=%h", k, got_v, exp_v);
            end
            n_checks++;
            if (TICK[0] !== ((k % 3) == 0) || TICK[1] !== ((k % 4) == 0) || TICK[2] !== ((k % 5) == 0) ||
                CLK_DIV[2] !== ((k % 5) >= 3)) begin
                n_fail++; $display("FAIL sync_align k=%0d tick=%b clk=%b", k, TICK, CLK_DIV);
            end
        end
    endtask

    task automatic test_async_rst();
        set_load(1, 9, 4);
        cycle();
        got_v = {CLK_DIV, TICK, PENDING, ERR}; exp_v = sb_q.pop_front(); n_checks++;
        if (got_v !== exp_v || PENDING[1] !== 1'b1) begin
            n_fail++; $display("FAIL prerst_pending got=%h exp=%h", got_v, exp_v);
        end
        #2;
        RST = 1'b1;
        #1;
        n_checks++;
        if ({CLK_DIV, TICK, PENDING, ERR} !== '0) begin
            n_fail++; $display("FAIL async_rst got=%h exp=0", {CLK_DIV, TICK, PENDING, ERR});
        end
        EN = 3'b000;
        #1;
        RST = 1'b0;
        model_reset();
        sb_q.delete();
        cycle();
        got_v = {CLK_DIV, TICK, PENDING, ERR}; exp_v = sb_q.pop_front(); n_checks++;
        if (got_v !== exp_v || got_v !== '0) begin
            n_fail++; $display("FAIL postrst_idle got=%h exp=%h", got_v, exp_v);
        end
        EN = 3'b011;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) set_load(0, 6, 3);
            cycle();
            got_v = {CLK_DIV, TICK, PENDING, ERR}; exp_v = sb_q.pop_front(); n_checks++;
            if (got_v !== exp_v) begin
                n_fail++; $display("FAIL postrst_sb k=%0d got=%h exp=%h", k, got_v, exp_v);
            end
            n_checks++;
            if (CLK_DIV[1:0] !== {2{(k >= 2)}} || TICK[1:0] !== {2{(k == 0)}} || PENDING !== 3'b000) begin
                n_fail++; $display("FAIL postrst_default k=%0d clk=%b tick=%b pend=%b", k, CLK_DIV, TICK, PENDING);
            end
        end
        for (int k = 0; k < 12; k++) begin
            cycle();
            got_v = {CLK_DIV, TICK, PENDING, ERR}; exp_v = sb_q.pop_front(); n_checks++;
            if (got_v !== exp_v) begin
                n_fail++; $display("FAIL wrapload_sb k=%0d got=%h exp=%h", k, got_v, exp_v);
            end
            n_checks++;
            if (CLK_DIV[0] !== ((k % 6) >= 3) || TICK[0] !== ((k % 6) == 0)) begin
                n_fail++; $display("FAIL wrapload_wave k=%0d clk0=%b tick0=%b", k, CLK_DIV[0], TICK[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reload();
        test_err();
        test_clamp();
        test_sync();
        test_async_rst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
